// File: rtl/blink_timer_pkg.sv
// Shared blink constants: default widths/levels, level-max macro, button decode.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
`ifndef BLINK_DEFS_SVH
`define BLINK_DEFS_SVH
// All-ones interval level for a level register of width w.
`define BLINK_LEVEL_MAX(w) {(w){1'b1}}
`endif

package blink_timer_pkg;

  localparam int BLINK_LEVEL_W_DEF       = 3;
  localparam int BLINK_DEFAULT_LEVEL_DEF = 3;

  typedef enum logic [1:0] {
    LVL_HOLD = 2'd0,
    LVL_DEC  = 2'd1,
    LVL_INC  = 2'd2
  } lvl_action_e;

  // Both buttons together cancel out, so only a lone press moves the level.
  function automatic lvl_action_e lvl_action(input logic faster, input logic slower);
    if (faster && !slower) return LVL_DEC;
    if (slower && !faster) return LVL_INC;
    return LVL_HOLD;
  endfunction

endpackage

// File: rtl/blink_timer_dffr.sv
// Generic W-bit flip-flop with synchronous active-high reset to RST_VAL.
// Latency: 1 cycle from d to q.
// Backpressure: none; loads every cycle.
module dffr #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         r,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Register d each cycle; r wins over d.
  always_ff @(posedge clk) begin
    if (r) q <= RST_VAL;
    else   q <= d;
  end

endmodule

// File: rtl/blink_timer.sv
// Beat-interval pulse source: one-cycle tick every (level+1) beats; faster/slower saturate the level.
// Latency: tick registered, one cycle after the beat on which count hits 0; level follows a button one cycle later.
// Backpressure: none. Optional macro BLINK_TIMER_PAUSE_EN adds a pause input that freezes the beat counter.
module blink_timer
  import blink_timer_pkg::*;
#(
  parameter int LEVEL_W       = BLINK_LEVEL_W_DEF,
  parameter int DEFAULT_LEVEL = BLINK_DEFAULT_LEVEL_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               beat,
  input  logic               faster,
  input  logic               slower,
`ifdef BLINK_TIMER_PAUSE_EN
  input  logic               pause,
`endif
  output logic               tick,
  output logic [LEVEL_W-1:0] level
);

  localparam logic [LEVEL_W-1:0] DEF_LVL   = LEVEL_W'(DEFAULT_LEVEL);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = `BLINK_LEVEL_MAX(LEVEL_W);
  localparam logic [LEVEL_W-1:0] ONE       = LEVEL_W'(1);

  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W-1:0] count_q, count_d;
  logic               tick_q,  tick_d;
  logic               beat_en;

`ifdef BLINK_TIMER_PAUSE_EN
  // A paused beat is simply not counted; buttons are still honoured.
  assign beat_en = beat & ~pause;
`else
  assign beat_en = beat;
`endif

  // Next-state: saturating level update and beat down-counter with reload from the pre-update level.
  always_comb begin
    level_d = level_q;
    count_d = count_q;
    tick_d  = 1'b0;
    unique case (lvl_action(faster, slower))
      LVL_DEC: if (level_q != '0)        level_d = level_q - ONE;
      LVL_INC: if (level_q != LEVEL_MAX) level_d = level_q + ONE;
      default: level_d = level_q;
    endcase
    if (beat_en) begin
      if (count_q == '0) begin
        // Reload uses the old level so a same-cycle button press waits for the next reload.
        count_d = level_q;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q - ONE;
      end
    end
  end

  dffr #(.W(LEVEL_W), .RST_VAL(DEF_LVL)) u_level_ff (.clk(clk), .r(rst), .d(level_d), .q(level_q));
  dffr #(.W(LEVEL_W), .RST_VAL(DEF_LVL)) u_count_ff (.clk(clk), .r(rst), .d(count_d), .q(count_q));
  dffr #(.W(1),       .RST_VAL(1'b0))    u_tick_ff  (.clk(clk), .r(rst), .d(tick_d),  .q(tick_q));

  assign tick  = tick_q;
  assign level = level_q;

endmodule

// File: tb/tb_blink_timer.sv
// Randomised + directed bench for blink_timer against a beat-counting reference model.
// Latency: model advances one step per rising edge; outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_blink_timer;

  localparam int LW  = 3;
  localparam int DEF = 3;
  localparam int MAXL = (1 << LW) - 1;

  logic          clk = 1'b0;
  logic          rst, beat, faster, slower, pause;
  logic          tick;
  logic [LW-1:0] level;

  int nvec = 0;
  int errs = 0;

  // Reference model: level as a plain integer, beats still owed before the next tick.
  int m_level, m_left, m_tick;

  always #5 clk = ~clk;

  blink_timer #(.LEVEL_W(LW), .DEFAULT_LEVEL(DEF)) dut (
    .clk    (clk),
    .rst    (rst),
    .beat   (beat),
    .faster (faster),
    .slower (slower),
`ifdef BLINK_TIMER_PAUSE_EN
    .pause  (pause),
`endif
    .tick   (tick),
    .level  (level)
  );

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic b, input logic f, input logic s, input logic p);
    int nt;
    if (r) begin
      m_level = DEF;
      m_left  = DEF;
      m_tick  = 0;
    end else begin
      nt = 0;
`ifdef BLINK_TIMER_PAUSE_EN
      if (b && !p) begin
`else
      if (b) begin
`endif
        if (m_left == 0) begin
          nt = 1;
          m_left = m_level;
        end else begin
          m_left = m_left - 1;
        end
      end
      if (f && !s) m_level = (m_level > 0) ? m_level - 1 : 0;
      if (s && !f) m_level = (m_level < MAXL) ? m_level + 1 : MAXL;
      m_tick = nt;
    end
  endtask

  // Apply one cycle of inputs, advance the model, and compare on the falling edge.
  task automatic step(input logic r, input logic b, input logic f, input logic s, input logic p);
    rst = r; beat = b; faster = f; slower = s; pause = p;
    @(posedge clk);
    model_step(r, b, f, s, p);
    @(negedge clk);
    chk("model_tick", int'(tick), m_tick);
    chk("model_level", int'(level), m_level);
  endtask

  initial begin
    int nticks;
    rst = 1'b1; beat = 1'b0; faster = 1'b0; slower = 1'b0; pause = 1'b0;
    m_level = DEF; m_left = DEF; m_tick = 0;
    @(negedge clk);
    step(1, 1, 1, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_level", int'(level), 3);

    // Beat every cycle: ticks after the 4th, 8th and 12th beat, one cycle wide.
    for (int i = 1; i <= 12; i++) begin
      step(0, 1, 0, 0, 0);
      chk($sformatf("t1_tick_%0d", i), int'(tick), (i % 4 == 0) ? 1 : 0);
    end

    // Beat every 4th cycle at level 3: one tick per 16 cycles.
    step(1, 0, 0, 0, 0);
    nticks = 0;
    for (int i = 0; i < 64; i++) begin
      step(0, (i % 4 == 0), 0, 0, 0);
      if (tick) begin
        nticks++;
        chk("t2_tick_after_beat", i % 16, 12);
      end
    end
    chk("t2_tick_count", nticks, 4);

    // Faster saturates at 0, slower saturates at 7.
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 1, 0, 0);
      chk($sformatf("t3_faster_%0d", i), int'(level), (3 - i > 0) ? 3 - i : 0);
    end
    // Count still holds 3: four beats drain it, then every beat ticks.
    for (int i = 1; i <= 7; i++) begin
      step(0, 1, 0, 0, 0);
      chk($sformatf("t3_drain_%0d", i), int'(tick), (i >= 4) ? 1 : 0);
    end
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, 0, 1, 0);
      chk($sformatf("t3_slower_%0d", i), int'(level), (i < 7) ? i : 7);
    end

    // Both buttons: level unchanged. Slower mid-interval: current interval 4 beats, next 5.
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0);
    chk("t4_both", int'(level), 3);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("t4_slower_level", int'(level), 4);
    step(0, 1, 0, 0, 0);
    chk("t4_beat3_notick", int'(tick), 0);
    step(0, 1, 0, 0, 0);
    chk("t4_beat4_tick", int'(tick), 1);
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, 0, 0, 0);
      chk($sformatf("t4_next_%0d", i), int'(tick), (i == 5) ? 1 : 0);
    end

    // Reset on the beat that would tick.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("t5_no_tick", int'(tick), 0);
    chk("t5_level", int'(level), 3);
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 0, 0, 0);
      chk($sformatf("t5_count_%0d", i), int'(tick), (i == 4) ? 1 : 0);
    end

`ifdef BLINK_TIMER_PAUSE_EN
    // Pause freezes the count with beat held high; two beats remain afterwards.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 0, 1);
      chk("t6_paused", int'(tick), 0);
    end
    step(0, 1, 0, 0, 0);
    chk("t6_resume1", int'(tick), 0);
    step(0, 1, 0, 0, 0);
    chk("t6_resume2", int'(tick), 1);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule

// File: doc/blink_timer.md
# blink_timer

Programmable beat-interval pulse source that drives the blinker's `switch` input. It counts incoming `beat` strobes and emits a one-cycle `tick` every (level+1) beats. `faster` / `slower` button pulses adjust the level with saturation. It sits between the beat divider and the blinker, so the blinker toggles once per `tick`.

## Interface
- `LEVEL_W`, default 3: width of the interval level and beat counter.
- `DEFAULT_LEVEL`, default 3: level and counter value loaded on reset; must be ≤ 2^LEVEL_W−1.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `beat`  in  1: one-cycle base-rate strobe.
- `faster`  in  1: one-cycle pulse (already debounced and edge-detected); shortens the interval by one beat.
- `slower`  in  1: one-cycle pulse; lengthens the interval by one beat.
- `tick`  out  1: one-cycle pulse, registered; connects to the blinker's `switch`.
- `level`  out  LEVEL_W: current interval setting; interval = level+1 beats.

## Operation
- State:
  - `level` register: reset to DEFAULT_LEVEL.
  - `count` register: reset to DEFAULT_LEVEL.
  - `tick` register: reset to 0.
- Level update, evaluated every cycle independent of `beat`:
  - `faster` only: level−1, saturating at 0.
  - `slower` only: level+1, saturating at 2^LEVEL_W−1.
  - Both or neither: level unchanged.
- Counter, when `beat`=1:
  - count≠0: count−1, and tick_next=0.
  - count=0: count reloads with the current `level` register value, i.e. the pre-update value in that cycle; tick_next=1.
- Counter, when `beat`=0: count holds, and tick_next=0.
- A level change never disturbs the in-flight count; it takes effect at the next reload.
  - Consequence: after `faster` to level 0, the running interval still finishes. Later intervals are 1 beat, so `tick` asserts every beat.
- All arithmetic is unsigned LEVEL_W-bit. Saturation is checked explicitly, never by wrap-around.

## Timing
- `tick` latency: asserted exactly one cycle after the beat on which count=0; high for exactly one cycle.
- Back-to-back ticks are possible when level=0 and `beat` is high every cycle.
- `level` output reflects a button pulse one cycle after the pulse.
- Reset:
  - `rst` high on any cycle, including mid-count or the cycle a tick would be produced, suppresses that tick.
  - Next cycle: tick=0, level=DEFAULT_LEVEL, count=DEFAULT_LEVEL.
  - `rst` overrides `beat`, `faster` and `slower` in the same cycle.
- After reset release, with `beat` every cycle, the first tick appears in the cycle after the (DEFAULT_LEVEL+1)-th beat.

## Configuration
- Macro: `BLINK_TIMER_PAUSE_EN`.
- Defined:
  - Adds input `pause` (in, 1).
  - While `pause`=1, `beat` is ignored: count holds and tick_next=0.
  - `faster` and `slower` are still accepted.
  - A tick already registered still completes its single cycle.
  - Releasing `pause` resumes the count from the held value.
- Undefined: no `pause` port; behaviour as if pause=0.

## Structure
- Shared include `blink_defs.vh` holds:
  - default LEVEL_W and DEFAULT_LEVEL constants;
  - `` `BLINK_LEVEL_MAX `` (all-ones level).
- All three registers use the existing `dffr` flip-flop module, with `r` driven by `rst`. No other sub-module.
- Next-state logic lives in one combinational block with every output assigned on every path.

## Test plan
Bench uses LEVEL_W=3, DEFAULT_LEVEL=3.
1. Reset, then `beat`=1 every cycle → `tick` pulses on cycles 4, 8, 12 after release; each pulse lasts one cycle.
2. `beat` every 4th cycle at level 3 → one tick per 16 cycles, each one cycle after the qualifying beat.
3. Four `faster` pulses from level 3 → `level` goes 2, 1, 0, 0 (saturates). After the current interval drains, `tick` asserts every beat. Eight `slower` pulses → `level` stops at 7; interval becomes 8 beats.
4. `faster` and `slower` in the same cycle → `level` unchanged. A `slower` pulse mid-interval → current interval length unchanged; the next interval is one beat longer.
5. `rst` asserted on the cycle count=0 with `beat`=1 → no tick. Following cycle: tick=0, level=3, count=3.
6. With `BLINK_TIMER_PAUSE_EN`: assert `pause` for 10 cycles mid-count with `beat` high → no ticks and count frozen. Tick resumes after the remaining beats once `pause` drops.
